spi_mem_ctrl: RTL and testbench
===============================

// Module: spi_mem_ctrl
// PURPOSE
//  Downstream bus slave for the CPU core: turns single-byte CPU bus reads and writes into SPI
//  transactions on an external 23LC512-style SRAM (mode 0, 16-bit addressing).
//  Stretches each access with bus_wait until the data is valid or the write has completed.
//  Sits between the CPU bus port and the chip's SPI I/O pins.
// PARAMETERS
//  CLK_DIV   1     SCK half-period in clk cycles (>=1); SCK = clk/(2*CLK_DIV)
//  CS_IDLE   1     minimum clk cycles spi_cs_n is held high between transactions (>=1)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  bus_address  in   16  byte address from CPU, stable while bus_read/bus_write is high
//  bus_data_wr  in   8   write data from CPU, stable while bus_write is high
//  bus_read     in   1   read request (level, held until bus_wait seen low)
//  bus_write    in   1   write request (level, held until bus_wait seen low)
//  bus_data_rd  out  8   read data, valid whenever bus_read=1 and bus_wait=0
//  bus_wait     out  1   combinational: (bus_read|bus_write) & ~done
//  spi_cs_n     out  1   chip select, active low
//  spi_sck      out  1   serial clock, idle low (mode 0)
//  spi_mosi     out  1   serial data out, MSB first
//  spi_miso     in   1   serial data in, sampled on SCK rising edge
// BEHAVIOUR
//  - Reset (async): state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, bus_data_rd=8'h00, done=0.
//    Reset mid-transaction aborts immediately: CS deasserts in the same instant.
//  - States: IDLE -> SHIFT -> CS_HOLD -> DONE -> IDLE.
//  - IDLE: on an edge with bus_read|bus_write high, latch frame = {op, bus_address, bus_data_wr}
//    with op 8'h03 for read, 8'h02 for write. Read has priority when both are high (illegal
//    combination; a read is performed). Then drive spi_cs_n=0, spi_mosi=frame[31], spi_sck=0,
//    bit_cnt=0, go to SHIFT.
//  - SHIFT: 32 bits. Each bit spends CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
//    On the rising transition, shift spi_miso into rx[7:0].
//    On the falling transition, advance spi_mosi to the next frame bit.
//    For reads, data bits (24..31) drive MOSI=0.
//    After the high half of bit 31: SCK=0, spi_cs_n=1, go to CS_HOLD.
//  - CS_HOLD: hold spi_cs_n=1 for CS_IDLE cycles. On exit, set done=1; for reads,
//    bus_data_rd <= rx. Go to DONE.
//  - DONE: done stays 1, so bus_wait=0, until both bus_read and bus_write are low.
//    Then clear done and return to IDLE; no new request is accepted in that cycle.
//  - bus_wait is high for exactly 1 + 64*CLK_DIV + CS_IDLE cycles, counted from the first cycle
//    the request is visible (CLK_DIV=1, CS_IDLE=1: 66 cycles).
//  - Request withdrawn during SHIFT: the transaction completes normally (no abort) and
//    the block returns to IDLE via DONE.
//  - bus_data_rd keeps its last read value across writes and idle periods.
//  - Address wraps naturally at 16'hFFFF (no special handling). Counters are sized for 32 bits and
//    CLK_DIV up to 255; no overflow is allowed.
// STRUCTURE
//  - spi_mem_defs.vh: SPI_CMD_READ (8'h03), SPI_CMD_WRITE (8'h02), state encodings
//    (`SPI_ST_*, 2 bits).
//  - One sub-module, spi_sck_gen: CLK_DIV prescaler with a run enable. Emits one-cycle rise/fall
//    strobes and the registered spi_sck level.
//  - Top level holds the FSM, the 32-bit TX shift register, the 8-bit RX shift register and bit_cnt.
// TESTING
//  - Reset: rst_n=0 mid-SHIFT -> spi_cs_n=1 and spi_sck=0 immediately; bus_data_rd=00;
//    bus_wait=0 once requests drop.
//  - Read 0x1234, SRAM model returns 0xA5 -> MOSI stream 03 12 34 00; bus_data_rd=A5;
//    bus_wait high 66 cycles (CLK_DIV=1, CS_IDLE=1).
//  - Write 0xBEEF <= 0x5A -> MOSI stream 02 BE EF 5A; model memory[BEEF]=5A;
//    bus_data_rd unchanged.
//  - CLK_DIV=3 read -> SCK period 6 clk; bus_wait high 1+192+1=194 cycles.
//  - bus_read and bus_write both high -> opcode 03 sent; no memory modified.
//  - Back-to-back: CPU drops bus_read and re-asserts it the next edge -> one idle cycle in DONE,
//    spi_cs_n high >= CS_IDLE cycles between frames; second read returns correct data.

Source files
------------

// File: rtl/spi_mem_ctrl_pkg.sv
// rtl/spi_mem_ctrl_pkg.sv - shared opcodes, FSM state constants and frame builder for spi_mem_ctrl
package spi_mem_ctrl_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_CS_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Reads clock out zeros in the data byte while the SRAM drives MISO.
  function automatic logic [31:0] build_frame(input logic        is_read,
                                              input logic [15:0] addr,
                                              input logic [7:0]  wdata);
    return is_read ? {SPI_CMD_READ, addr, 8'h00} : {SPI_CMD_WRITE, addr, wdata};
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// rtl/spi_mem_ctrl_if.sv - CPU-side byte bus between the core (master) and spi_mem_ctrl (slave)
interface spi_mem_ctrl_if;

  logic [15:0] bus_address;
  logic [7:0]  bus_data_wr;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_data_rd;
  logic        bus_wait;

  modport master (
    output bus_address, bus_data_wr, bus_read, bus_write,
    input  bus_data_rd, bus_wait
  );

  modport slave (
    input  bus_address, bus_data_wr, bus_read, bus_write,
    output bus_data_rd, bus_wait
  );

endinterface

// File: rtl/spi_mem_ctrl_sck_gen.sv
// rtl/spi_mem_ctrl_sck_gen.sv - CLK_DIV prescaler producing the registered SCK level and edge strobes
module spi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic rise_o,
  output logic fall_o,
  output logic sck_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sck_q, sck_d;
  logic          wrap;

  assign wrap   = run_i && (div_cnt_q == CW'(CLK_DIV - 1));
  // Strobes are high in the cycle whose closing edge flips sck_q.
  assign rise_o = wrap & ~sck_q;
  assign fall_o = wrap & sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    if (!run_i) begin
      div_cnt_d = '0;
      sck_d     = 1'b0;
    end else if (wrap) begin
      div_cnt_d = '0;
      sck_d     = ~sck_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// rtl/spi_mem_ctrl.sv - CPU byte bus to mode-0 SPI SRAM bridge, stretching accesses with bus_wait
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_IDLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_mem_ctrl_if.slave  bus,
  output logic           spi_cs_n,
  output logic           spi_sck,
  output logic           spi_mosi,
  input  logic           spi_miso
);

  logic [1:0]  state_q, state_d;
  logic [31:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        cs_n_q, cs_n_d;
  logic        done_q, done_d;
  logic        is_read_q, is_read_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        req, sck_rise, sck_fall;

  assign req             = bus.bus_read | bus.bus_write;
  assign bus.bus_wait    = req & ~done_q;
  assign bus.bus_data_rd = rd_data_q;
  assign spi_cs_n        = cs_n_q;
  assign spi_mosi        = tx_q[31];

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (state_q == ST_SHIFT),
    .rise_o (sck_rise),
    .fall_o (sck_fall),
    .sck_o  (spi_sck)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    cs_n_d     = cs_n_q;
    done_d     = done_q;
    is_read_d  = is_read_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          is_read_d = bus.bus_read;
          tx_d      = build_frame(bus.bus_read, bus.bus_address, bus.bus_data_wr);
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sck_rise) rx_d = {rx_q[6:0], spi_miso};
        if (sck_fall) begin
          tx_d = {tx_q[30:0], 1'b0};
          if (bit_cnt_q == 5'd31) begin
            cs_n_d     = 1'b1;
            hold_cnt_d = '0;
            state_d    = ST_CS_HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      ST_CS_HOLD: begin
        if (hold_cnt_q == 16'(CS_IDLE - 1)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
          if (is_read_q) rd_data_d = rx_q;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        // The cycle spent here with req low keeps a held-over level from starting a new frame.
        if (!req) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
      is_read_q  <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
      is_read_q  <= is_read_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb/tb_spi_mem_ctrl.sv - self-checking bench: two divider settings against an SPI SRAM reference model
module tb_spi_mem_ctrl;

  localparam int DIV_A = 1, IDLE_A = 1, DIV_B = 3, IDLE_B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_ctrl_if ifa ();
  spi_mem_ctrl_if ifb ();
  logic cs_a, sck_a, mosi_a, miso_a;
  logic cs_b, sck_b, mosi_b, miso_b;

  spi_mem_ctrl #(.CLK_DIV(DIV_A), .CS_IDLE(IDLE_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa),
    .spi_cs_n(cs_a), .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a));

  spi_mem_ctrl #(.CLK_DIV(DIV_B), .CS_IDLE(IDLE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb),
    .spi_cs_n(cs_b), .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b));

  logic [7:0] mem [0:65535];
  logic [7:0] last_rd [0:1];
  int         last_rise_cyc [0:1];
  int         n_cmp = 0, n_fail = 0;
  int         cyc = 0;

  always @(negedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [7:0] d);
    if (sel == 0) begin
      ifa.bus_read = rd; ifa.bus_write = wr; ifa.bus_address = a; ifa.bus_data_wr = d;
    end else begin
      ifb.bus_read = rd; ifb.bus_write = wr; ifb.bus_address = a; ifb.bus_data_wr = d;
    end
  endtask

  task automatic set_miso(input int sel, input logic v);
    if (sel == 0) miso_a = v; else miso_b = v;
  endtask

  function automatic logic [3:0] pins(input int sel);
    return (sel != 0) ? {ifb.bus_wait, cs_b, sck_b, mosi_b} : {ifa.bus_wait, cs_a, sck_a, mosi_a};
  endfunction

  function automatic logic [7:0] rdata(input int sel);
    return (sel != 0) ? ifb.bus_data_rd : ifa.bus_data_rd;
  endfunction

  // Drives one bus access, plays the SRAM on the SPI pins, then checks the frame and bus results.
  task automatic run_txn(input int sel, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [7:0] d, input string tag);
    int div, idl, waitc, nbits, rise_prev, period, idx;
    bit ended;
    logic [31:0] cap, exp_frame;
    logic [7:0]  m_op, b, exp_rd;
    logic [15:0] m_addr;
    logic        prev_sck, prev_cs;
    logic [3:0]  p;
    div = (sel != 0) ? DIV_B : DIV_A;
    idl = (sel != 0) ? IDLE_B : IDLE_A;
    exp_frame = rd ? {8'h03, a, 8'h00} : {8'h02, a, d};
    exp_rd = rd ? mem[a] : last_rd[sel];
    waitc = 0; nbits = 0; cap = '0; rise_prev = -1; period = -1; ended = 0;
    prev_sck = 1'b0; prev_cs = 1'b1; m_op = 8'h00; m_addr = '0;
    @(negedge clk);
    set_req(sel, rd, wr, a, d);
    for (int k = 0; k < 2000; k++) begin
      #1;
      p = pins(sel);
      if (!p[3]) begin ended = 1; break; end
      waitc++;
      if (prev_cs && !p[2])
        chk({tag, "_cs_gap"}, 64'((cyc - last_rise_cyc[sel]) >= idl), 64'd1);
      if (!prev_cs && p[2]) last_rise_cyc[sel] = cyc;
      if (!prev_sck && p[1]) begin
        cap = {cap[30:0], p[0]};
        nbits++;
        if (nbits == 24) begin m_op = cap[23:16]; m_addr = cap[15:0]; end
        if (rise_prev >= 0 && period < 0) period = k - rise_prev;
        rise_prev = k;
      end
      if (prev_sck && !p[1] && nbits >= 24 && nbits < 32 && m_op == 8'h03) begin
        b = mem[m_addr];
        idx = 31 - nbits;
        set_miso(sel, b[idx]);
      end
      prev_sck = p[1];
      prev_cs  = p[2];
      @(negedge clk);
    end
    chk({tag, "_ended"}, 64'(ended), 64'd1);
    chk({tag, "_wait_cycles"}, 64'(waitc), 64'(1 + 64 * div + idl));
    chk({tag, "_mosi_frame"}, 64'(cap), 64'(exp_frame));
    chk({tag, "_sck_period"}, 64'(period), 64'(2 * div));
    chk({tag, "_cs_at_done"}, 64'(p[2]), 64'd1);
    if (m_op == 8'h02) mem[m_addr] = cap[7:0];
    if (rd) last_rd[sel] = exp_rd;
    chk({tag, "_rdata"}, 64'(rdata(sel)), 64'(exp_rd));
    set_req(sel, 0, 0, a, d);
    set_miso(sel, 1'b0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rdv;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h1234] = 8'hA5;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    last_rise_cyc[0] = -1000; last_rise_cyc[1] = -1000;
    set_req(0, 0, 0, 16'h0000, 8'h00);
    set_req(1, 0, 0, 16'h0000, 8'h00);
    miso_a = 1'b0; miso_b = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_n", 64'(cs_a), 64'd1);
    chk("rst_sck", 64'(sck_a), 64'd0);
    chk("rst_mosi", 64'(mosi_a), 64'd0);
    chk("rst_rdata", 64'(ifa.bus_data_rd), 64'h00);
    chk("rst_wait", 64'(ifa.bus_wait), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(0, 1, 0, 16'h1234, 8'h00, "rd1234");
    run_txn(0, 0, 1, 16'hBEEF, 8'h5A, "wrBEEF");
    run_txn(0, 1, 0, 16'hBEEF, 8'h00, "rdBEEF");
    run_txn(1, 1, 0, 16'h1234, 8'h00, "div3_rd");
    run_txn(1, 0, 1, 16'hFFFF, 8'hC3, "div3_wr");
    run_txn(1, 1, 0, 16'hFFFF, 8'h00, "div3_rdFFFF");
    run_txn(0, 1, 1, 16'h0042, 8'h77, "both");
    run_txn(0, 1, 0, 16'h0042, 8'h00, "both_check");

    for (int i = 0; i < 12; i++) begin
      ra  = 16'hFFF8 + 16'($urandom_range(0, 7));
      rdv = 8'($urandom);
      if ($urandom_range(0, 1) != 0)
        run_txn(i % 2, 1, 0, ra, 8'h00, $sformatf("rnd%0d_rd", i));
      else
        run_txn(i % 2, 0, 1, ra, rdv, $sformatf("rnd%0d_wr", i));
    end

    @(negedge clk);
    set_req(0, 1, 0, 16'h0042, 8'h00);
    repeat (20) @(negedge clk);
    #1;
    chk("mid_shift_cs", 64'(cs_a), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 64'(cs_a), 64'd1);
    chk("abort_sck", 64'(sck_a), 64'd0);
    chk("abort_rdata_a", 64'(ifa.bus_data_rd), 64'h00);
    chk("abort_rdata_b", 64'(ifb.bus_data_rd), 64'h00);
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    set_req(0, 0, 0, 16'h0000, 8'h00);
    #1;
    chk("abort_wait", 64'(ifa.bus_wait), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rise_cyc[0] = -1000; last_rise_cyc[1] = -1000;

    run_txn(0, 0, 1, 16'h2000, 8'h3C, "post_rst_wr");
    run_txn(1, 1, 0, 16'hBEEF, 8'h00, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
